// File: rtl/dla_hld_ram_stream_reader_pkg.sv
// dla_hld_ram_stream_reader_pkg: shared FSM type and read-latency limits for the RAM stream reader
package dla_hld_ram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;
  function automatic bit read_latency_ok(int l);
    return l >= MIN_READ_LATENCY && l <= MAX_READ_LATENCY;
  endfunction
endpackage

// File: rtl/dla_hld_ram_stream_reader_outbuf.sv
// dla_hld_ram_stream_reader_outbuf: small register FIFO holding returned {last, data} words
module dla_hld_ram_stream_reader_outbuf
  import dla_hld_ram_stream_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_en ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr <= rd_en ? ptr_inc(rd_ptr) : rd_ptr;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  // Storage needs no reset: a word is only visible once counted in.
  always_ff @(posedge clock)
    if (wr_en) mem[wr_ptr] <= wr_data;
  assign rd_data = mem[rd_ptr];
  assign empty = count == '0;
endmodule

// File: rtl/dla_hld_ram_stream_reader.sv
// dla_hld_ram_stream_reader: streams a wrapping range of RAM words out of a fixed-latency read port,
// with credit flow control so the small output buffer can never overflow under backpressure.
module dla_hld_ram_stream_reader
  import dla_hld_ram_stream_reader_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int READ_LATENCY = 2,
  localparam int ADDR = $clog2(DEPTH),
  localparam int OUTBUF_DEPTH = READ_LATENCY + 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDR-1:0]  cmd_base_addr,
  input  logic [ADDR:0]    cmd_count,
  output logic [ADDR-1:0]  ram_address,
  output logic             ram_read_enable,
  output logic             ram_in_clock_en,
  output logic             ram_out_clock_en,
  input  logic [WIDTH-1:0] ram_readdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(OUTBUF_DEPTH + 1);
  if (!read_latency_ok(READ_LATENCY) || DEPTH < 2) begin : g_bad_param
    $error("dla_hld_ram_stream_reader: illegal DEPTH or READ_LATENCY");
  end
  state_t state, state_nxt;
  logic [ADDR-1:0] addr;
  logic [ADDR:0] remaining;
  logic [CW-1:0] credits;
  logic [READ_LATENCY-1:0] pipe_valid, pipe_last;
  logic issue, issue_last, pop, buf_empty;
  logic [WIDTH:0] buf_word;
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    issue = state == ISSUE && credits != '0;
    issue_last = issue && remaining == (ADDR + 1)'(1);
    state_nxt = state;
    if (cmd_ready && cmd_valid && cmd_count != '0) state_nxt = ISSUE;
    if (issue_last) state_nxt = DRAIN;
    if (state == DRAIN && pop && out_last) state_nxt = IDLE;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      credits <= CW'(OUTBUF_DEPTH);
      pipe_valid <= '0;
      pipe_last <= '0;
      addr <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      credits <= credits - CW'(issue) + CW'(pop);
      // Shift the issue strobe in at bit 0; the top bit lines up with ram_readdata.
      pipe_valid <= READ_LATENCY'({pipe_valid, issue});
      pipe_last <= READ_LATENCY'({pipe_last, issue_last});
      if (cmd_ready && cmd_valid) begin
        addr <= cmd_base_addr;
        remaining <= cmd_count;
      end else if (issue) begin
        addr <= addr == ADDR'(DEPTH - 1) ? '0 : addr + ADDR'(1);
        remaining <= remaining - (ADDR + 1)'(1);
      end
    end
  dla_hld_ram_stream_reader_outbuf #(
    .DEPTH(OUTBUF_DEPTH),
    .WIDTH(WIDTH + 1)
  ) u_outbuf (
    .clock(clock),
    .resetn(resetn),
    .wr_en(pipe_valid[READ_LATENCY-1]),
    .wr_data({pipe_last[READ_LATENCY-1], ram_readdata}),
    .rd_en(pop),
    .rd_data(buf_word),
    .empty(buf_empty)
  );
  assign out_valid = !buf_empty;
  assign out_data = buf_word[WIDTH-1:0];
  assign out_last = out_valid && buf_word[WIDTH];
  assign pop = out_valid && out_ready;
  assign ram_address = addr;
  assign ram_read_enable = issue;
  assign ram_in_clock_en = 1'b1;
  assign ram_out_clock_en = 1'b1;
endmodule

// File: doc/dla_hld_ram_stream_reader.md
DLA_HLD_RAM_STREAM_READER -- requirements
Module: dla_hld_ram_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 512, words in the attached RAM, >=2, need not be a power of two.
REQ-002 SHALL have parameter WIDTH, default 32, data bits per word.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from ram_read_enable to valid ram_readdata, legal 1..4.
REQ-004 SHALL have localparams ADDR = $clog2(DEPTH) and OUTBUF_DEPTH = READ_LATENCY+2.
REQ-005 SHALL have port: clock  in  1  sole clock.
REQ-006 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: cmd_valid  in  1  command offered.
REQ-008 SHALL have port: cmd_ready  out  1  command accepted when both high.
REQ-009 SHALL have port: cmd_base_addr  in  ADDR  first word address.
REQ-010 SHALL have port: cmd_count  in  ADDR+1  words to read, 0..DEPTH.
REQ-011 SHALL have port: ram_address  out  ADDR  RAM port-b address.
REQ-012 SHALL have port: ram_read_enable  out  1  RAM port-b read strobe.
REQ-013 SHALL have port: ram_in_clock_en  out  1  tied 1.
REQ-014 SHALL have port: ram_out_clock_en  out  1  tied 1.
REQ-015 SHALL have port: ram_readdata  in  WIDTH  RAM port-b data.
REQ-016 SHALL have port: out_valid  out  1  stream word available.
REQ-017 SHALL have port: out_ready  in  1  consumer accepts.
REQ-018 SHALL have port: out_data  out  WIDTH  stream word.
REQ-019 SHALL have port: out_last  out  1  marks final word of a command.
REQ-020 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN; cmd_ready=1 only in IDLE.
REQ-022 In IDLE, a handshake with cmd_count=0 SHALL be consumed with no reads and no output, and the FSM SHALL stay in IDLE.
REQ-023 In IDLE, a handshake with cmd_count>0 SHALL latch base and count and go to ISSUE.
REQ-024 In ISSUE, a read SHALL be issued each cycle in which credits>0.
REQ-025 Issued addresses SHALL be base, base+1, ..., wrapping from DEPTH-1 to 0.
REQ-026 After the read issue for the last word, the FSM SHALL go to DRAIN.
REQ-027 DRAIN SHALL return to IDLE in the cycle after the out_last word handshakes.
REQ-028 Credits SHALL reset to OUTBUF_DEPTH; next = credits - issue + pop, so a simultaneous issue and pop leaves credits unchanged.
REQ-029 A READ_LATENCY-deep valid/last shift register SHALL track reads in flight, and returning data SHALL be written into the output buffer on arrival.
REQ-030 The output buffer SHALL never overflow; that is guaranteed by credits.
REQ-031 If ram_read_enable is high in cycle c, the word SHALL be presented no earlier than cycle c+READ_LATENCY+1.
REQ-032 For a handshake in cycle 0, the first ram_read_enable SHALL be in cycle 1 and out_valid SHALL rise in cycle READ_LATENCY+2.
REQ-033 With out_ready held high, throughput SHALL be one word per cycle.
REQ-034 out_valid/out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-035 Words SHALL be delivered in issue order, with none dropped or duplicated.

Reset
REQ-036 On resetn low (any cycle, including mid-command), the block SHALL set: state IDLE, credits OUTBUF_DEPTH, in-flight pipe cleared, buffer empty, out_valid=0, out_last=0, ram_read_enable=0, busy=0.
REQ-037 After reset, cmd_ready SHALL be 1; out_data SHALL be don't-care.
REQ-038 RAM data returning after a reset SHALL be ignored.

Structure
REQ-039 Package dla_hld_ram_stream_reader_pkg SHALL hold the state enum and the READ_LATENCY legal-range constants.
REQ-040 Sub-module dla_hld_ram_stream_reader_outbuf SHALL be a register-based FIFO of depth OUTBUF_DEPTH, width WIDTH+1 (data, last), with async active-low reset.

Verification
REQ-041 The bench SHALL cover: DEPTH=16, L=2, base=3, count=4, out_ready=1 -> addresses 3,4,5,6 in cycles 1-4; out_valid cycles 4-7; out_last in cycle 7; busy falls in cycle 8.
REQ-042 The bench SHALL cover: DEPTH=12, base=10, count=5 -> addresses 10,11,0,1,2; data in that order.
REQ-043 The bench SHALL cover: count=20, L=3, out_ready low for 10 cycles -> reads stop after 5 outstanding (credits 0), data held stable, and no loss after release.
REQ-044 The bench SHALL cover: cmd_count=0 -> no ram_read_enable, no out_valid, cmd_ready stays 1, busy stays 0.
REQ-045 The bench SHALL cover: resetn low during DRAIN with 3 words buffered -> all outputs reset immediately; a new command returns only its own data.
REQ-046 The bench SHALL cover: randomized out_ready over 1000 commands at L=1..4 -> scoreboard matches the RAM model, and exactly one out_last is seen per nonzero command.
